// File: rtl/id_ex_ctrl_pkg.sv
// id_ex_ctrl_pkg
// Shared control encodings for the ID/EX control path: ALU operation
// codes, MIPS opcode/funct constants, the EX control bundle and its
// bubble value, and a sign-extension helper.
// Optional feature macro used by the top: ID_EX_BUBBLE_CNT_EN.
package id_ex_ctrl_pkg;

  // ADD must stay at zero so that an all-zero bubble decodes as ADD.
  typedef enum logic [3:0] {
    ALUop_ADD  = 4'h0,
    ALUop_SUB  = 4'h1,
    ALUop_ORI  = 4'h2,
    ALUop_AND  = 4'h3,
    ALUop_NOR  = 4'h4,
    ALUop_SLL  = 4'h5,
    ALUop_SRL  = 4'h6,
    ALUop_SRA  = 4'h7,
    ALUop_SLT  = 4'h8,
    ALUop_SLTU = 4'h9,
    ALUop_XOR  = 4'hA
  } aluop_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] F_SLL  = 6'h00;
  localparam logic [5:0] F_SRL  = 6'h02;
  localparam logic [5:0] F_SRA  = 6'h03;
  localparam logic [5:0] F_ADD  = 6'h20;
  localparam logic [5:0] F_ADDU = 6'h21;
  localparam logic [5:0] F_SUB  = 6'h22;
  localparam logic [5:0] F_SUBU = 6'h23;
  localparam logic [5:0] F_AND  = 6'h24;
  localparam logic [5:0] F_OR   = 6'h25;
  localparam logic [5:0] F_XOR  = 6'h26;
  localparam logic [5:0] F_NOR  = 6'h27;
  localparam logic [5:0] F_SLT  = 6'h2A;
  localparam logic [5:0] F_SLTU = 6'h2B;

  // Everything the EX stage consumes, except the PC copy.
  typedef struct packed {
    logic        valid;
    aluop_e      aluop;
    logic [4:0]  shamt;
    logic        alusrc;
    logic        azero;
    logic [31:0] imm;
    logic        regwrite;
    logic [4:0]  wreg;
    logic        memread;
    logic        memwrite;
    logic        illegal;
  } ctrl_t;

  localparam ctrl_t CTRL_BUBBLE = '0;

  function automatic logic [31:0] sign_ext16(input logic [15:0] imm);
    return {{16{imm[15]}}, imm};
  endfunction

endpackage

// File: rtl/id_ex_ctrl_decode.sv
// ctrl_decode
// Pure combinational decoder: instruction word -> EX control bundle.
// Ports:
//   instr_i  in  32  ID-stage instruction word
//   ctrl_o   out     decoded control bundle (valid is always 1 here;
//                    the top decides whether a bubble is loaded instead)
module ctrl_decode
  import id_ex_ctrl_pkg::*;
(
  input  logic [31:0] instr_i,
  output ctrl_t       ctrl_o
);

  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [15:0] imm;
  logic        legal;
  logic        unused_rs;

  assign opcode    = instr_i[31:26];
  assign funct     = instr_i[5:0];
  assign rt        = instr_i[20:16];
  assign rd        = instr_i[15:11];
  assign imm       = instr_i[15:0];
  assign unused_rs = ^instr_i[25:21];

  // Decode by opcode, then by funct for R-type. Write-back is assumed on
  // and cleared for stores, for $0 destinations and for illegal words.
  always_comb begin
    ctrl_o          = CTRL_BUBBLE;
    ctrl_o.valid    = 1'b1;
    ctrl_o.regwrite = 1'b1;
    legal           = 1'b1;
    case (opcode)
      OP_RTYPE: begin
        ctrl_o.wreg = rd;
        case (funct)
          F_ADD, F_ADDU: ctrl_o.aluop = ALUop_ADD;
          F_SUB, F_SUBU: ctrl_o.aluop = ALUop_SUB;
          F_AND:         ctrl_o.aluop = ALUop_AND;
          F_OR:          ctrl_o.aluop = ALUop_ORI;
          F_XOR:         ctrl_o.aluop = ALUop_XOR;
          F_NOR:         ctrl_o.aluop = ALUop_NOR;
          F_SLT:         ctrl_o.aluop = ALUop_SLT;
          F_SLTU:        ctrl_o.aluop = ALUop_SLTU;
          F_SLL: begin
            ctrl_o.aluop = ALUop_SLL;
            ctrl_o.shamt = instr_i[10:6];
          end
          F_SRL: begin
            ctrl_o.aluop = ALUop_SRL;
            ctrl_o.shamt = instr_i[10:6];
          end
          F_SRA: begin
            ctrl_o.aluop = ALUop_SRA;
            ctrl_o.shamt = instr_i[10:6];
          end
          default: legal = 1'b0;
        endcase
      end
      OP_ADDI, OP_ADDIU, OP_LW, OP_SW: begin
        ctrl_o.alusrc   = 1'b1;
        ctrl_o.wreg     = rt;
        ctrl_o.aluop    = ALUop_ADD;
        ctrl_o.imm      = sign_ext16(imm);
        ctrl_o.memread  = (opcode == OP_LW);
        ctrl_o.memwrite = (opcode == OP_SW);
        ctrl_o.regwrite = (opcode != OP_SW);
      end
      OP_SLTI, OP_SLTIU: begin
        ctrl_o.alusrc = 1'b1;
        ctrl_o.wreg   = rt;
        ctrl_o.aluop  = (opcode == OP_SLTI) ? ALUop_SLT : ALUop_SLTU;
        ctrl_o.imm    = sign_ext16(imm);
      end
      OP_ANDI, OP_ORI, OP_XORI: begin
        ctrl_o.alusrc = 1'b1;
        ctrl_o.wreg   = rt;
        ctrl_o.imm    = {16'h0, imm};
        case (opcode)
          OP_ANDI: ctrl_o.aluop = ALUop_AND;
          OP_ORI:  ctrl_o.aluop = ALUop_ORI;
          default: ctrl_o.aluop = ALUop_XOR;
        endcase
      end
      OP_LUI: begin
        ctrl_o.alusrc = 1'b1;
        ctrl_o.wreg   = rt;
        ctrl_o.aluop  = ALUop_ORI;
        ctrl_o.imm    = {imm, 16'h0};
        ctrl_o.azero  = 1'b1;
      end
      default: legal = 1'b0;
    endcase

    if (!legal) begin
      ctrl_o         = CTRL_BUBBLE;
      ctrl_o.valid   = 1'b1;
      ctrl_o.illegal = 1'b1;
    end else if (ctrl_o.wreg == 5'd0) begin
      ctrl_o.regwrite = 1'b0;
    end
  end

endmodule

// File: rtl/id_ex_ctrl.sv
// id_ex_ctrl
// ID/EX pipeline register for the decoded control bundle, with
// reset > flush > stall > load priority.
// Ports:
//   clk, rst_n (async, active-low); id_valid, id_instr, id_pc from ID;
//   stall (hold), flush (bubble) from the hazard unit;
//   ex_* registered controls and PC copy for the EX stage.
// Optional: define ID_EX_BUBBLE_CNT_EN to add bubble_cnt (32-bit count of
// bubbles loaded by flush or by id_valid=0; stalls are not counted).
module id_ex_ctrl
  import id_ex_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        id_valid,
  input  logic [31:0] id_instr,
  input  logic [31:0] id_pc,
  input  logic        stall,
  input  logic        flush,
  output logic        ex_valid,
  output logic [3:0]  ex_aluop,
  output logic [4:0]  ex_shamt,
  output logic        ex_alusrc,
  output logic        ex_azero,
  output logic [31:0] ex_imm,
  output logic        ex_regwrite,
  output logic [4:0]  ex_wreg,
  output logic        ex_memread,
  output logic        ex_memwrite,
  output logic        ex_illegal,
  output logic [31:0] ex_pc
`ifdef ID_EX_BUBBLE_CNT_EN
  ,
  output logic [31:0] bubble_cnt
`endif
);

  ctrl_t       dec;
  ctrl_t       ctrl_d, ctrl_q;
  logic [31:0] pc_d, pc_q;
  logic        bubble_load;

  ctrl_decode u_decode (
    .instr_i (id_instr),
    .ctrl_o  (dec)
  );

  // Flush beats stall; an empty ID slot loads a bubble only when not stalled.
  always_comb begin
    ctrl_d      = ctrl_q;
    pc_d        = pc_q;
    bubble_load = 1'b0;
    if (flush) begin
      ctrl_d      = CTRL_BUBBLE;
      pc_d        = '0;
      bubble_load = 1'b1;
    end else if (!stall) begin
      if (id_valid) begin
        ctrl_d = dec;
        pc_d   = id_pc;
      end else begin
        ctrl_d      = CTRL_BUBBLE;
        pc_d        = '0;
        bubble_load = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_q <= CTRL_BUBBLE;
      pc_q   <= '0;
    end else begin
      ctrl_q <= ctrl_d;
      pc_q   <= pc_d;
    end
  end

`ifdef ID_EX_BUBBLE_CNT_EN
  logic [31:0] bubble_cnt_q;

  // Free-running wrap-around count of loaded bubbles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bubble_cnt_q <= '0;
    end else if (bubble_load) begin
      bubble_cnt_q <= bubble_cnt_q + 32'd1;
    end
  end

  assign bubble_cnt = bubble_cnt_q;
`else
  logic unused_bubble_load;
  assign unused_bubble_load = bubble_load;
`endif

  assign ex_valid    = ctrl_q.valid;
  assign ex_aluop    = ctrl_q.aluop;
  assign ex_shamt    = ctrl_q.shamt;
  assign ex_alusrc   = ctrl_q.alusrc;
  assign ex_azero    = ctrl_q.azero;
  assign ex_imm      = ctrl_q.imm;
  assign ex_regwrite = ctrl_q.regwrite;
  assign ex_wreg     = ctrl_q.wreg;
  assign ex_memread  = ctrl_q.memread;
  assign ex_memwrite = ctrl_q.memwrite;
  assign ex_illegal  = ctrl_q.illegal;
  assign ex_pc       = pc_q;

endmodule

// File: tb/tb_id_ex_ctrl.sv
// tb_id_ex_ctrl
// Self-checking bench for id_ex_ctrl: directed instruction sequence,
// stall/flush/reset scenarios, then randomized traffic, all compared
// against a table-driven reference model of the decode rules.
// Honours ID_EX_BUBBLE_CNT_EN when the design is built with it.
module tb_id_ex_ctrl;
  import id_ex_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_valid;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic        stall;
  logic        flush;
  logic        ex_valid;
  logic [3:0]  ex_aluop;
  logic [4:0]  ex_shamt;
  logic        ex_alusrc;
  logic        ex_azero;
  logic [31:0] ex_imm;
  logic        ex_regwrite;
  logic [4:0]  ex_wreg;
  logic        ex_memread;
  logic        ex_memwrite;
  logic        ex_illegal;
  logic [31:0] ex_pc;
`ifdef ID_EX_BUBBLE_CNT_EN
  logic [31:0] bubble_cnt;
`endif

  id_ex_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .id_valid    (id_valid),
    .id_instr    (id_instr),
    .id_pc       (id_pc),
    .stall       (stall),
    .flush       (flush),
    .ex_valid    (ex_valid),
    .ex_aluop    (ex_aluop),
    .ex_shamt    (ex_shamt),
    .ex_alusrc   (ex_alusrc),
    .ex_azero    (ex_azero),
    .ex_imm      (ex_imm),
    .ex_regwrite (ex_regwrite),
    .ex_wreg     (ex_wreg),
    .ex_memread  (ex_memread),
    .ex_memwrite (ex_memwrite),
    .ex_illegal  (ex_illegal),
    .ex_pc       (ex_pc)
`ifdef ID_EX_BUBBLE_CNT_EN
    ,
    .bubble_cnt  (bubble_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    bit        valid;
    bit [3:0]  aluop;
    bit [4:0]  shamt;
    bit        alusrc;
    bit        azero;
    bit [31:0] imm;
    bit        regwrite;
    bit [4:0]  wreg;
    bit        memread;
    bit        memwrite;
    bit        illegal;
    bit [31:0] pc;
  } exp_t;

  exp_t        expQ;
  bit   [31:0] expBubbles;
  int          errors;
  int          checks;

  // Lookup tables: funct -> ALU op for R-type, opcode -> ALU op for I-type.
  int rOp[int];
  int iOp[int];

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  // Reference decode written from the instruction-set rules.
  function automatic exp_t modelDecode(input bit [31:0] w);
    exp_t    e;
    bit [5:0] op;
    bit [5:0] fn;
    bit [15:0] im;
    e  = '0;
    op = w[31:26];
    fn = w[5:0];
    im = w[15:0];
    e.valid = 1'b1;
    if (op == 6'h00 && rOp.exists(fn)) begin
      e.aluop    = 4'(rOp[fn]);
      e.wreg     = w[15:11];
      e.shamt    = (fn == 6'h00 || fn == 6'h02 || fn == 6'h03) ? w[10:6] : 5'd0;
      e.regwrite = (e.wreg != 0);
    end else if (op != 6'h00 && iOp.exists(op)) begin
      e.aluop  = 4'(iOp[op]);
      e.alusrc = 1'b1;
      e.wreg   = w[20:16];
      if (op == 6'h0F) begin
        e.imm   = im * 32'h10000;
        e.azero = 1'b1;
      end else if (op >= 6'h0C && op <= 6'h0E) begin
        e.imm = 32'(im);
      end else begin
        e.imm = (im >= 16'h8000) ? (32'(im) + 32'hFFFF0000) : 32'(im);
      end
      e.memread  = (op == 6'h23);
      e.memwrite = (op == 6'h2B);
      e.regwrite = !e.memwrite && (e.wreg != 0);
    end else begin
      e.illegal = 1'b1;
    end
    return e;
  endfunction

  task automatic checkAll(input string tag);
    checkOutput({tag, ".valid"},    32'(ex_valid),    32'(expQ.valid));
    checkOutput({tag, ".aluop"},    32'(ex_aluop),    32'(expQ.aluop));
    checkOutput({tag, ".shamt"},    32'(ex_shamt),    32'(expQ.shamt));
    checkOutput({tag, ".alusrc"},   32'(ex_alusrc),   32'(expQ.alusrc));
    checkOutput({tag, ".azero"},    32'(ex_azero),    32'(expQ.azero));
    checkOutput({tag, ".imm"},      ex_imm,           expQ.imm);
    checkOutput({tag, ".regwrite"}, 32'(ex_regwrite), 32'(expQ.regwrite));
    checkOutput({tag, ".wreg"},     32'(ex_wreg),     32'(expQ.wreg));
    checkOutput({tag, ".memread"},  32'(ex_memread),  32'(expQ.memread));
    checkOutput({tag, ".memwrite"}, 32'(ex_memwrite), 32'(expQ.memwrite));
    checkOutput({tag, ".illegal"},  32'(ex_illegal),  32'(expQ.illegal));
    checkOutput({tag, ".pc"},       ex_pc,            expQ.pc);
`ifdef ID_EX_BUBBLE_CNT_EN
    checkOutput({tag, ".bubble_cnt"}, bubble_cnt, expBubbles);
`endif
  endtask

  // Drive one cycle of ID inputs, advance the model at the edge, then check.
  task automatic applyStimulus(input string tag, input bit v, input bit [31:0] instr,
                               input bit [31:0] pc, input bit st, input bit fl);
    id_valid = v;
    id_instr = instr;
    id_pc    = pc;
    stall    = st;
    flush    = fl;
    @(posedge clk);
    if (fl) begin
      expQ = '0;
      expBubbles++;
    end else if (!st) begin
      if (v) begin
        expQ    = modelDecode(instr);
        expQ.pc = pc;
      end else begin
        expQ = '0;
        expBubbles++;
      end
    end
    #1;
    checkAll(tag);
  endtask

  function automatic bit [31:0] randInstr();
    bit [5:0] rF[15] = '{6'h00, 6'h02, 6'h03, 6'h20, 6'h21, 6'h22, 6'h23, 6'h24,
                         6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B, 6'h01, 6'h3F};
    bit [5:0] iO[12] = '{6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F,
                         6'h23, 6'h2B, 6'h04, 6'h3F};
    bit [31:0] w;
    int        sel;
    w   = $urandom;
    sel = int'($urandom_range(0, 9));
    if (sel < 5) begin
      w[31:26] = 6'h00;
      w[5:0]   = rF[$urandom_range(0, 14)];
    end else if (sel < 9) begin
      w[31:26] = iO[$urandom_range(0, 11)];
    end
    if ($urandom_range(0, 7) == 0) w[20:11] = '0;
    return w;
  endfunction

  initial begin
    errors     = 0;
    checks     = 0;
    expQ       = '0;
    expBubbles = '0;

    rOp[6'h20] = ALUop_ADD;  rOp[6'h21] = ALUop_ADD;
    rOp[6'h22] = ALUop_SUB;  rOp[6'h23] = ALUop_SUB;
    rOp[6'h24] = ALUop_AND;  rOp[6'h25] = ALUop_ORI;
    rOp[6'h26] = ALUop_XOR;  rOp[6'h27] = ALUop_NOR;
    rOp[6'h2A] = ALUop_SLT;  rOp[6'h2B] = ALUop_SLTU;
    rOp[6'h00] = ALUop_SLL;  rOp[6'h02] = ALUop_SRL;
    rOp[6'h03] = ALUop_SRA;
    iOp[6'h08] = ALUop_ADD;  iOp[6'h09] = ALUop_ADD;
    iOp[6'h0A] = ALUop_SLT;  iOp[6'h0B] = ALUop_SLTU;
    iOp[6'h0C] = ALUop_AND;  iOp[6'h0D] = ALUop_ORI;
    iOp[6'h0E] = ALUop_XOR;  iOp[6'h0F] = ALUop_ORI;
    iOp[6'h23] = ALUop_ADD;  iOp[6'h2B] = ALUop_ADD;

    rst_n    = 1'b0;
    id_valid = 1'b0;
    id_instr = '0;
    id_pc    = '0;
    stall    = 1'b0;
    flush    = 1'b0;
    #12;
    checkAll("reset");
    @(negedge clk);
    rst_n = 1'b1;

    applyStimulus("addu",  1, 32'h00221821, 32'h00400000, 0, 0);
    applyStimulus("ori",   1, 32'h34051234, 32'h00400004, 0, 0);
    applyStimulus("lui",   1, 32'h3C05ABCD, 32'h00400008, 0, 0);
    applyStimulus("sll",   1, 32'h000220C0, 32'h0040000C, 0, 0);
    applyStimulus("nop",   1, 32'h00000000, 32'h00400010, 0, 0);
    applyStimulus("lw",    1, 32'h8C22FFFC, 32'h00400014, 0, 0);
    applyStimulus("stall1", 1, 32'h00221821, 32'h00400018, 1, 0);
    applyStimulus("stall2", 1, 32'h3C05ABCD, 32'h0040001C, 1, 0);
    applyStimulus("stall3", 0, 32'hFC000000, 32'h00400020, 1, 0);
    applyStimulus("sw",    1, 32'hAC22FFF0, 32'h00400024, 0, 0);
    applyStimulus("stflush", 1, 32'h00221821, 32'h00400028, 1, 1);
    applyStimulus("stbubble", 1, 32'h00221821, 32'h0040002C, 1, 0);
    applyStimulus("idle",  0, 32'h00221821, 32'h00400030, 0, 0);
    applyStimulus("illegal", 1, 32'hFC000000, 32'h00400034, 0, 0);
    applyStimulus("badfn", 1, 32'h00221801, 32'h00400038, 0, 0);
    applyStimulus("slti",  1, 32'h2843FFFF, 32'h0040003C, 0, 0);

    // Asynchronous reset mid-cycle: outputs clear before the next edge.
    #2;
    rst_n = 1'b0;
    #1;
    expQ       = '0;
    expBubbles = '0;
    checkAll("asyncrst");
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus("postrst", 1, 32'h00221821, 32'h00400040, 0, 0);

    for (int i = 0; i < 400; i++) begin
      applyStimulus("rand", ($urandom_range(0, 99) < 85), randInstr(), $urandom,
                    ($urandom_range(0, 3) == 0), ($urandom_range(0, 9) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
